// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the digit-serial subtractor:
//   - FSM state encodings (IDLE / RUN / DONE)
//   - slice-counter width helper (clog2 of the slice count, minimum 1 bit)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of a counter that must index slices 0 .. n-1.
  // A single-slice operation still needs a 1-bit counter register.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_sub_digit.sv
// -----------------------------------------------------------------------------
// sub_digit
// Combinational DIGIT-bit borrow-ripple subtractor: d = x - y - bi.
//
// Ports
//   x  [DIGIT-1:0] in  : minuend slice
//   y  [DIGIT-1:0] in  : subtrahend slice
//   bi             in  : borrow into the least significant bit
//   d  [DIGIT-1:0] out : difference slice
//   bo             out : borrow out of the most significant bit
// -----------------------------------------------------------------------------
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic brw;

  always_comb begin
    brw = bi;
    d   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ brw;
      // A bit position borrows when x is 0 and something is taken from it,
      // or when both y and the incoming borrow must be taken.
      brw  = (~x[i] & (y[i] | brw)) | (y[i] & brw);
    end
    bo = brw;
  end

endmodule : sub_digit

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Digit-serial subtractor computing a - b - bin over WIDTH/DIGIT clock cycles,
// least significant slice first, with unsigned borrow-out and signed overflow.
//
// Parameters
//   WIDTH : operand width (2..64)
//   DIGIT : bits processed per cycle (must divide WIDTH)
//
// Ports
//   clk              in  : clock, rising edge
//   rst              in  : synchronous active-high reset
//   start            in  : begin a subtraction (ignored while busy)
//   a, b [WIDTH-1:0] in  : minuend / subtrahend, sampled on accepted start
//   bin              in  : borrow-in, sampled on accepted start
//   busy             out : high for the N processing cycles
//   done             out : one-cycle completion pulse
//   diff [WIDTH-1:0] out : a - b - bin modulo 2^WIDTH
//   bout             out : unsigned borrow-out (a < b + bin)
//   ovf              out : two's-complement overflow
//
// diff/bout/ovf are registered and change only when an operation completes,
// so downstream logic never sees a partially assembled result.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if ((WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be in 2..64");
    end
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must divide WIDTH");
    end
  endgenerate

  // Signed overflow of a - b: only possible when the operands differ in sign,
  // and visible as a result whose sign disagrees with the minuend.
  function automatic logic sub_ovf(input logic a_sgn, input logic b_sgn,
                                   input logic d_sgn);
    return (a_sgn != b_sgn) && (d_sgn != a_sgn);
  endfunction

  // Control state
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             brw;

  // Datapath state (not reset: contents only matter after an accepted start)
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             a_sgn;
  logic             b_sgn;

  logic             accept;
  logic             last;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bo;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] d_next;

  assign accept = !rst && start && (state != ST_RUN);
  assign last   = (state == ST_RUN) && (cnt == CNT_LAST);

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .bi (brw),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // The result register fills from the top: each new slice enters at the
  // MSB end, so after N shifts the first slice sits at bit 0.
  always_comb begin
    slice_ext              = '0;
    slice_ext[DIGIT-1:0]   = slice_d;
    d_next = (d_sh >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
  end

  // Control: FSM, slice counter, borrow chain, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            brw   <= bin;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          brw <= slice_bo;
          cnt <= cnt + CNT_ONE;
          if (last) begin
            state <= ST_DONE;
            diff  <= d_next;
            bout  <= slice_bo;
            ovf   <= sub_ovf(a_sgn, b_sgn, d_next[WIDTH-1]);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand shift registers and partial result
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      a_sgn <= a[WIDTH-1];
      b_sgn <= b[WIDTH-1];
    end else if (state == ST_RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      d_sh <= d_next;
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor. Two instances share the operand
// inputs: WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4; sel picks which one a start
// goes to and whose outputs are observed. Expected results come from plain
// integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;

  logic       start1, start4;
  logic       busy1, done1, bout1, ovf1;
  logic       busy4, done4, bout4, ovf4;
  logic [7:0] diff1, diff4;

  logic       busy_s, done_s, bout_s, ovf_s;
  logic [7:0] diff_s;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start4 = start & sel;

  assign busy_s = sel ? busy4 : busy1;
  assign done_s = sel ? done4 : done1;
  assign diff_s = sel ? diff4 : diff1;
  assign bout_s = sel ? bout4 : bout1;
  assign ovf_s  = sel ? ovf4  : ovf1;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1),
    .ovf   (ovf1)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4),
    .ovf   (ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: 8-bit a - b - bin by integer arithmetic.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                input logic mbin, output logic [7:0] d,
                                output logic bo, output logic ov);
    int ua, ub, bi, r, sa, sb, sr;
    ua = int'(ma);
    ub = int'(mb);
    bi = mbin ? 1 : 0;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = ua - ub - bi;
    sr = sa - sb - bi;
    d  = r[7:0];
    bo = (ua < ub + bi);
    ov = (sr < -128) || (sr > 127);
  endfunction

  function automatic int cur_n();
    return sel ? 2 : 8;
  endfunction

  // Called right after the accepting edge. Returns edges until done is seen,
  // busy cycles, and a count of anomalies (busy with done, or the result
  // outputs moving before completion).
  task automatic wait_done(output int edges, output int busyc,
                           output int anom);
    logic [7:0] d0;
    edges = 0;
    anom  = 0;
    busyc = busy_s ? 1 : 0;
    d0    = diff_s;
    for (int i = 0; i < 100; i++) begin
      tick;
      edges++;
      if (busy_s && done_s) anom++;
      if (done_s) break;
      if (busy_s) busyc++;
      if (diff_s !== d0) anom++;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] ea,
                           input logic [7:0] eb, input logic ebin);
    logic [7:0] d;
    logic       bo, ov;
    model(ea, eb, ebin, d, bo, ov);
    chk({tag, ".diff"}, 64'(diff_s), 64'(d));
    chk({tag, ".bout"}, 64'(bout_s), 64'(bo));
    chk({tag, ".ovf"},  64'(ovf_s),  64'(ov));
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta,
                        input logic [7:0] tb, input logic tbin);
    int edges, busyc, anom;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(edges, busyc, anom);
    chk({tag, ".latency"}, 64'(edges), 64'(cur_n()));
    chk({tag, ".busy_cycles"}, 64'(busyc), 64'(cur_n()));
    chk({tag, ".anomalies"}, 64'(anom), 64'd0);
    check_res(tag, ta, tb, tbin);
  endtask

  initial begin
    int edges, busyc, anom, dcount;
    logic [7:0] ra, rb;
    logic       rbin;

    rst = 1'b1; start = 1'b0; sel = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    tick;
    tick;

    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset.busy", 64'(busy_s), 64'd0);
      chk("reset.done", 64'(done_s), 64'd0);
      chk("reset.diff", 64'(diff_s), 64'd0);
      chk("reset.bout", 64'(bout_s), 64'd0);
      chk("reset.ovf",  64'(ovf_s),  64'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    tick;

    // Directed cases, DIGIT=1.
    run_op("d1_05_03",   8'h05, 8'h03, 1'b0);
    chk("d1_05_03.diff_const", 64'(diff_s), 64'h02);
    run_op("d1_03_05",   8'h03, 8'h05, 1'b0);
    chk("d1_03_05.diff_const", 64'(diff_s), 64'hFE);
    chk("d1_03_05.bout_const", 64'(bout_s), 64'd1);
    run_op("d1_00_00_b", 8'h00, 8'h00, 1'b1);
    chk("d1_00_00_b.diff_const", 64'(diff_s), 64'hFF);
    run_op("d1_80_01",   8'h80, 8'h01, 1'b0);
    chk("d1_80_01.diff_const", 64'(diff_s), 64'h7F);
    chk("d1_80_01.ovf_const",  64'(ovf_s),  64'd1);
    run_op("d1_7f_ff",   8'h7F, 8'hFF, 1'b0);
    chk("d1_7f_ff.diff_const", 64'(diff_s), 64'h80);
    chk("d1_7f_ff.ovf_const",  64'(ovf_s),  64'd1);
    run_op("d1_eq",      8'h5A, 8'h5A, 1'b0);
    chk("d1_eq.diff_const", 64'(diff_s), 64'h00);
    run_op("d1_ff_ff_b", 8'hFF, 8'hFF, 1'b1);
    run_op("d1_80_00_b", 8'h80, 8'h00, 1'b1);

    // Result and done hold/clear after completion.
    tick;
    chk("hold.done", 64'(done_s), 64'd0);
    tick;
    tick;
    check_res("hold", 8'h80, 8'h00, 1'b1);

    // Start pulsed mid-RUN with different operands is ignored.
    a = 8'h3C; b = 8'h11; bin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    a = 8'hEE; b = 8'h77; bin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(edges, busyc, anom);
    chk("midstart.latency", 64'(edges + 3), 64'd8);
    check_res("midstart", 8'h3C, 8'h11, 1'b0);

    // Start held high through DONE: second operation with no idle cycle.
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    tick;
    a = 8'hC8; b = 8'h19; bin = 1'b1;
    wait_done(edges, busyc, anom);
    chk("b2b1.latency", 64'(edges), 64'd8);
    chk("b2b1.anomalies", 64'(anom), 64'd0);
    check_res("b2b1", 8'h05, 8'h03, 1'b0);
    tick;
    start = 1'b0;
    chk("b2b.nogap_busy", 64'(busy_s), 64'd1);
    chk("b2b.nogap_done", 64'(done_s), 64'd0);
    wait_done(edges, busyc, anom);
    chk("b2b2.latency", 64'(edges), 64'd8);
    chk("b2b2.busy_cycles", 64'(busyc), 64'd8);
    check_res("b2b2", 8'hC8, 8'h19, 1'b1);

    // Reset on the 4th RUN cycle aborts with no done pulse.
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort.busy", 64'(busy_s), 64'd0);
    chk("abort.done", 64'(done_s), 64'd0);
    chk("abort.diff", 64'(diff_s), 64'd0);
    chk("abort.bout", 64'(bout_s), 64'd0);
    chk("abort.ovf",  64'(ovf_s),  64'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done_s || busy_s) dcount++;
    end
    chk("abort.no_activity", 64'(dcount), 64'd0);
    run_op("after_abort", 8'h9D, 8'h2E, 1'b1);

    // rst wins over a simultaneous start.
    a = 8'h44; b = 8'h22; start = 1'b1; rst = 1'b1;
    tick;
    start = 1'b0; rst = 1'b0;
    chk("rst_prio.busy", 64'(busy_s), 64'd0);
    tick;

    // DIGIT=4 instance.
    sel = 1'b1;
    #1;
    run_op("d4_a3_5c", 8'hA3, 8'h5C, 1'b0);
    chk("d4_a3_5c.diff_const", 64'(diff_s), 64'h47);
    chk("d4_a3_5c.ovf_const",  64'(ovf_s),  64'd1);
    chk("d4_a3_5c.bout_const", 64'(bout_s), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      if ((i % 16) == 0) rb = ra;
      run_op("rand_d4", ra, rb, rbin);
    end

    sel = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      run_op("rand_d1", ra, rb, rbin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_subtractor
